// File: rtl/oled_pkg.sv
// Shared geometry defaults and FSM encodings for the OLED framebuffer streamer.
package oled_pkg;

  localparam int unsigned OledCols   = 128;
  localparam int unsigned OledPages  = 8;
  localparam int unsigned FrameBytes = OledCols * OledPages;
  localparam int unsigned FbAddrW    = $clog2(FrameBytes);

  typedef enum logic [1:0] {
    WrIdle,
    WrRmw,
    WrClr
  } wr_state_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } st_state_e;

endpackage

// File: rtl/oled_fb_ram.sv
// Frame byte store: one write port and two independent synchronous read ports.
// A read and a write to the same address in one cycle return the old byte.
module oled_fb_ram
  import oled_pkg::*;
#(
  parameter int unsigned Depth = FrameBytes,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic             re_a,
  input  logic [AddrW-1:0] raddr_a,
  output logic [7:0]       rdata_a,
  input  logic             re_b,
  input  logic [AddrW-1:0] raddr_b,
  output logic [7:0]       rdata_b
);

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re_a) begin
      rdata_a <= mem_q[raddr_a];
    end
    if (re_b) begin
      rdata_b <= mem_q[raddr_b];
    end
  end

endmodule

// File: rtl/oled_fb_streamer.sv
// 128x64 monochrome framebuffer: pixel RMW writes, bulk clear, GDDRAM-ordered byte stream.
// Optional OLED_FB_INVERT_EN adds an invert input applied to streamed bytes.
module oled_fb_streamer
  import oled_pkg::*;
#(
  parameter int unsigned COLS  = OledCols,
  parameter int unsigned PAGES = OledPages
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(COLS)-1:0]      wr_x,
  input  logic [$clog2(PAGES*8)-1:0]   wr_y,
  input  logic                         wr_val,
  output logic                         wr_ready,
  input  logic                         clear,
  input  logic                         clear_val,
  input  logic                         frame_start,
`ifdef OLED_FB_INVERT_EN
  input  logic                         invert,
`endif
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy
);

  localparam int unsigned NumBytes = COLS * PAGES;
  localparam int unsigned XW       = $clog2(COLS);
  localparam int unsigned YW       = $clog2(PAGES * 8);
  localparam int unsigned AW       = $clog2(NumBytes);
  localparam logic [AW-1:0] LastAddr = AW'(NumBytes - 1);

  // Pixel address decode
  logic [AW-1:0] pix_addr;
  logic [XW:0]   x_ext;
  logic [YW:0]   y_ext;
  logic          in_range;

  assign pix_addr = AW'(wr_y[YW-1:3]) * AW'(COLS) + AW'(wr_x);
  assign x_ext    = {1'b0, wr_x};
  assign y_ext    = {1'b0, wr_y};
  assign in_range = (x_ext < (XW+1)'(COLS)) && (y_ext < (YW+1)'(PAGES * 8));

  // RAM hookup
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          ram_re_a;
  logic [7:0]    ram_rdata_a;
  logic          ram_re_b;
  logic [7:0]    ram_rdata_b;

  // Write FSM state
  wr_state_e     wr_state_q, wr_state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [7:0]    fill_q, fill_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [2:0]    pend_bit_q, pend_bit_d;
  logic          pend_val_q, pend_val_d;
  logic          pend_ok_q, pend_ok_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= WrIdle;
      clr_addr_q  <= '0;
      fill_q      <= '0;
      pend_addr_q <= '0;
      pend_bit_q  <= '0;
      pend_val_q  <= 1'b0;
      pend_ok_q   <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      clr_addr_q  <= clr_addr_d;
      fill_q      <= fill_d;
      pend_addr_q <= pend_addr_d;
      pend_bit_q  <= pend_bit_d;
      pend_val_q  <= pend_val_d;
      pend_ok_q   <= pend_ok_d;
    end
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    clr_addr_d  = clr_addr_q;
    fill_d      = fill_q;
    pend_addr_d = pend_addr_q;
    pend_bit_d  = pend_bit_q;
    pend_val_d  = pend_val_q;
    pend_ok_d   = pend_ok_q;
    ram_we      = 1'b0;
    ram_waddr   = clr_addr_q;
    ram_wdata   = fill_q;
    ram_re_a    = 1'b0;
    wr_ready    = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        wr_ready = 1'b1;
        if (clear) begin
          // clear has priority over a simultaneous pixel write
          wr_state_d = WrClr;
          clr_addr_d = '0;
          fill_d     = {8{clear_val}};
        end else if (wr_en) begin
          ram_re_a    = in_range;
          pend_addr_d = pix_addr;
          pend_bit_d  = wr_y[2:0];
          pend_val_d  = wr_val;
          pend_ok_d   = in_range;
          wr_state_d  = WrRmw;
        end
      end
      WrRmw: begin
        ram_we                = pend_ok_q;
        ram_waddr             = pend_addr_q;
        ram_wdata             = ram_rdata_a;
        ram_wdata[pend_bit_q] = pend_val_q;
        wr_state_d            = WrIdle;
      end
      WrClr: begin
        ram_we = 1'b1;
        if (clr_addr_q == LastAddr) begin
          wr_state_d = WrIdle;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // Stream FSM state
  st_state_e     st_state_q, st_state_d;
  logic [AW-1:0] st_addr_q, st_addr_d;
  logic [7:0]    st_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_state_q <= StIdle;
      st_addr_q  <= '0;
    end else begin
      st_state_q <= st_state_d;
      st_addr_q  <= st_addr_d;
    end
  end

  always_comb begin
    st_state_d = st_state_q;
    st_addr_d  = st_addr_q;
    ram_re_b   = 1'b0;
    unique case (st_state_q)
      StIdle: begin
        if (frame_start) begin
          st_state_d = StFetch;
          st_addr_d  = '0;
        end
      end
      StFetch: begin
        // Read only here so the held byte cannot change under concurrent writes
        ram_re_b   = 1'b1;
        st_state_d = StHold;
      end
      StHold: begin
        if (out_ready) begin
          if (st_addr_q == LastAddr) begin
            st_state_d = StIdle;
          end else begin
            st_addr_d  = st_addr_q + AW'(1);
            st_state_d = StFetch;
          end
        end
      end
      default: st_state_d = StIdle;
    endcase
  end

`ifdef OLED_FB_INVERT_EN
  logic inv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (st_state_q == StFetch) begin
      inv_q <= invert;
    end
  end

  assign st_byte = ram_rdata_b ^ {8{inv_q}};
`else
  assign st_byte = ram_rdata_b;
`endif

  assign out_valid = (st_state_q == StHold);
  assign out_data  = out_valid ? st_byte : 8'h00;
  assign out_last  = out_valid && (st_addr_q == LastAddr);
  assign busy      = (st_state_q != StIdle);

  oled_fb_ram #(
    .Depth (NumBytes),
    .AddrW (AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re_a    (ram_re_a),
    .raddr_a (pix_addr),
    .rdata_a (ram_rdata_a),
    .re_b    (ram_re_b),
    .raddr_b (st_addr_q),
    .rdata_b (ram_rdata_b)
  );

endmodule
